freq_meas_ctrl: RTL

FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

---
 rtl/freq_meas_pkg.sv | 26 ++
 rtl/freq_meas_ctrl_if.sv | 26 ++
 rtl/freq_meas_ctrl_lock_hyst.sv | 56 +++++
 rtl/freq_meas_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the frequency-measurement controller.
// Pure definitions: no latency, no flow control.
package freq_meas_pkg;

  localparam int CNT_W = 24;
  localparam logic [CNT_W-1:0] SAT_COUNT = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_GAP
  } state_t;

  // Widened by one bit so the magnitude can never wrap.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic [CNT_W:0] ea;
    logic [CNT_W:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

endpackage

// File: rtl/freq_meas_ctrl_if.sv
// Control/result bundle between the measurement controller and its user.
// Level signals plus single-cycle strobes; no backpressure.
interface freq_meas_ctrl_if;
  import freq_meas_pkg::*;

  logic             run;
  logic [CNT_W-1:0] expected;
  logic [CNT_W-1:0] tolerance;
  logic             fmeas_enable;
  logic [CNT_W-1:0] fmeas_count;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             in_range;
  logic             locked;
  logic             lock_lost;

  modport master (
    output run, expected, tolerance, fmeas_count,
    input  fmeas_enable, result, result_valid, in_range, locked, lock_lost
  );

  modport slave (
    input  run, expected, tolerance, fmeas_count,
    output fmeas_enable, result, result_valid, in_range, locked, lock_lost
  );
endinterface

// File: rtl/freq_meas_ctrl_lock_hyst.sv
// Lock hysteresis: LOCK_N consecutive good samples to lock, UNLOCK_N bad to drop.
// Outputs update on the sample edge; lock_lost is a one-cycle strobe, no backpressure.
module lock_hyst #(
  parameter int unsigned LOCK_N   = 3,
  parameter int unsigned UNLOCK_N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_valid,
  input  logic in_range,
  output logic locked,
  output logic lock_lost
);

  localparam logic [7:0] LOCK_MAX   = 8'(LOCK_N);
  localparam logic [7:0] UNLOCK_MAX = 8'(UNLOCK_N);

  logic [7:0] r_in_cnt;
  logic [7:0] r_out_cnt;
  logic       r_locked;
  logic       r_lock_lost;
  logic [7:0] w_in_nxt;
  logic [7:0] w_out_nxt;

  assign w_in_nxt  = (r_in_cnt  == LOCK_MAX)   ? r_in_cnt  : r_in_cnt  + 8'd1;
  assign w_out_nxt = (r_out_cnt == UNLOCK_MAX) ? r_out_cnt : r_out_cnt + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;
      if (sample_valid) begin
        if (in_range) begin
          r_out_cnt <= '0;
          r_in_cnt  <= w_in_nxt;
          if (w_in_nxt == LOCK_MAX) r_locked <= 1'b1;
        end else begin
          r_in_cnt  <= '0;
          r_out_cnt <= w_out_nxt;
          if (w_out_nxt == UNLOCK_MAX) begin
            r_locked    <= 1'b0;
            r_lock_lost <= r_locked;
          end
        end
      end
    end
  end

  assign locked    = r_locked;
  assign lock_lost = r_lock_lost;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Sequences gate/settle/capture/gap windows for an external edge counter and judges lock.
// Result one cycle after CAPTURE; no backpressure, run low aborts an open window.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 10000000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES    = 1000,
  parameter int unsigned LOCK_N        = 3,
  parameter int unsigned UNLOCK_N      = 2
) (
  input logic             clk,
  input logic             reset,
  freq_meas_ctrl_if.slave bus
);

  state_t           r_state;
  logic [31:0]      r_cnt;
  logic             r_fmeas_enable;
  logic [CNT_W-1:0] r_result;
  logic             r_result_valid;
  logic             r_in_range;

  logic [CNT_W:0]   w_diff;
  logic             w_in_range;
  logic             w_capture;
  logic             w_locked;
  logic             w_lock_lost;

  // A saturated counter means the test clock overran the window; never trust it.
  assign w_diff     = abs_diff(bus.fmeas_count, bus.expected);
  assign w_in_range = (w_diff <= {1'b0, bus.tolerance}) && (bus.fmeas_count != SAT_COUNT);
  assign w_capture  = (r_state == ST_CAPTURE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_fmeas_enable <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_in_range     <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (bus.run) begin
            r_state        <= ST_GATE;
            r_fmeas_enable <= 1'b1;
          end
        end
        ST_GATE: begin
          if (!bus.run) begin
            r_state        <= ST_IDLE;
            r_fmeas_enable <= 1'b0;
            r_cnt          <= '0;
          end else if (r_cnt == GATE_CYCLES - 32'd1) begin
            r_state        <= ST_SETTLE;
            r_fmeas_enable <= 1'b0;
            r_cnt          <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_SETTLE: begin
          if (!bus.run) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == SETTLE_CYCLES - 32'd1) begin
            r_state <= ST_CAPTURE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_CAPTURE: begin
          r_result       <= bus.fmeas_count;
          r_in_range     <= w_in_range;
          r_result_valid <= 1'b1;
          r_state        <= ST_GAP;
          r_cnt          <= '0;
        end
        ST_GAP: begin
          if (r_cnt == GAP_CYCLES - 32'd1) begin
            r_cnt <= '0;
            if (bus.run) begin
              r_state        <= ST_GATE;
              r_fmeas_enable <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_fmeas_enable <= 1'b0;
          r_cnt          <= '0;
        end
      endcase
    end
  end

  lock_hyst #(
    .LOCK_N   (LOCK_N),
    .UNLOCK_N (UNLOCK_N)
  ) u_lock_hyst (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (w_capture),
    .in_range     (w_in_range),
    .locked       (w_locked),
    .lock_lost    (w_lock_lost)
  );

  assign bus.fmeas_enable = r_fmeas_enable;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.in_range     = r_in_range;
  assign bus.locked       = w_locked;
  assign bus.lock_lost    = w_lock_lost;

endmodule
